// File: rtl/cpu_btb_update_controller.sv
// BTB write sequencer: buffers taken-branch updates in a FIFO drained on drain_en, and sweeps every set on flush_req.
// Optional macro BTB_UPDATE_FILTER_EN suppresses updates whose prediction was already correct.
module cpu_btb_update_controller #(
  parameter int XLEN        = 32,
  parameter int BYTE_OFFSET = 2,
  parameter int SET_WIDTH   = 8,
  parameter int DEPTH       = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 resolve_valid,
  input  logic [XLEN-1:0]      resolve_pc,
  input  logic                 resolve_taken,
  input  logic [XLEN-1:0]      resolve_target,
  input  logic                 resolve_pred_hit,
  input  logic [XLEN-1:0]      resolve_pred_target,
  input  logic                 drain_en,
  input  logic                 flush_req,
  output logic                 btb_update,
  output logic [XLEN-1:0]      btb_update_addr,
  output logic [XLEN-1:0]      btb_update_target,
  output logic                 btb_inval,
  output logic [SET_WIDTH-1:0] btb_inval_set,
  output logic                 flush_busy,
  output logic                 dropped
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int PC_W  = XLEN - BYTE_OFFSET;
  localparam logic [SET_WIDTH-1:0] LAST_SET = '1;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t state, state_next;

  logic [PC_W-1:0]      pc_mem  [DEPTH];
  logic [XLEN-1:0]      tgt_mem [DEPTH];
  logic [PTR_W:0]       wr_ptr, rd_ptr;
  logic [SET_WIDTH-1:0] set_cnt;

  logic in_idle, empty, full, filtered, eligible, accept_window, push, pop, drop_now;

  // Branches the BTB already predicts correctly need no rewrite.
`ifdef BTB_UPDATE_FILTER_EN
  assign filtered = resolve_pred_hit && (resolve_pred_target == resolve_target);
`else
  logic unused_pred;
  assign unused_pred = ^{resolve_pred_hit, resolve_pred_target};
  assign filtered    = 1'b0;
`endif

  logic unused_pc_low;
  assign unused_pc_low = ^resolve_pc[BYTE_OFFSET-1:0];

  assign in_idle       = (state == IDLE);
  assign empty         = (wr_ptr == rd_ptr);
  assign full          = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                         (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign eligible      = resolve_valid && resolve_taken && !filtered;
  // A flush cycle discards its own resolve, so it can neither push nor drop.
  assign accept_window = in_idle && !flush_req;
  assign pop           = in_idle && !empty && drain_en;
  assign push          = accept_window && eligible && (!full || pop);
  assign drop_now      = accept_window && eligible && full && !pop;

  // State register
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  // NOTE: the default assignment up front keeps this combinational block latch-free.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (flush_req) state_next = SWEEP;
      SWEEP:   if (!flush_req && set_cnt == LAST_SET) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Set counter: restarts on any flush request, advances one set per sweep cycle.
  always_ff @(posedge clk) begin
    if (rst || flush_req) set_cnt <= '0;
    else if (state == SWEEP) set_cnt <= set_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || (in_idle && flush_req)) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr[PTR_W-1:0]]  <= resolve_pc[XLEN-1:BYTE_OFFSET];
      tgt_mem[wr_ptr[PTR_W-1:0]] <= resolve_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) dropped <= 1'b0;
    else     dropped <= drop_now;
  end

  // Output logic
  always_comb begin
    btb_update        = pop;
    btb_update_addr   = {pc_mem[rd_ptr[PTR_W-1:0]], {BYTE_OFFSET{1'b0}}};
    btb_update_target = tgt_mem[rd_ptr[PTR_W-1:0]];
    btb_inval         = (state == SWEEP);
    btb_inval_set     = set_cnt;
    flush_busy        = (state == SWEEP);
  end

endmodule

// File: doc/cpu_btb_update_controller.md
# cpu_btb_update_controller

Sequences all writes into the branch target buffer. Resolved taken branches from the execute stage are buffered in a small FIFO and drained into the BTB write port only on cycles where the fetch stage grants the port. A flush request (fence.i, context switch) triggers a set-by-set invalidation sweep. The block sits between the execute stage and the BTB write/invalidate ports.

## Interface
- `XLEN`, 32, address width
- `BYTE_OFFSET`, 2, low PC bits ignored by the BTB
- `SET_WIDTH`, 8, BTB set index width (the BTB has 2^SET_WIDTH sets)
- `DEPTH`, 4, update FIFO entries; power of two, ≥2
- `clk`  in  1  clock; everything is sampled on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `resolve_valid`  in  1  a branch resolved this cycle
- `resolve_pc`  in  XLEN  branch PC
- `resolve_taken`  in  1  branch was taken
- `resolve_target`  in  XLEN  computed target
- `resolve_pred_hit`  in  1  BTB hit recorded at fetch for this branch
- `resolve_pred_target`  in  XLEN  target predicted at fetch
- `drain_en`  in  1  BTB write port free this cycle
- `flush_req`  in  1  single-cycle request to invalidate the whole BTB
- `btb_update`  out  1  BTB write strobe
- `btb_update_addr`  out  XLEN  write PC
- `btb_update_target`  out  XLEN  write target
- `btb_inval`  out  1  invalidate strobe
- `btb_inval_set`  out  SET_WIDTH  set to invalidate
- `flush_busy`  out  1  sweep in progress
- `dropped`  out  1  single-cycle pulse: an eligible update was lost because the FIFO was full

## Operation
- **Eligibility.** A resolve is eligible when `resolve_valid && resolve_taken`. Not-taken resolves are always ignored.
- **FIFO storage.** Each entry holds `resolve_pc[XLEN-1:BYTE_OFFSET]` and the full `resolve_target`. `btb_update_addr` re-expands the stored PC with its low BYTE_OFFSET bits set to zero.
- **States.**
  - IDLE: accepts and drains updates.
  - SWEEP: invalidates sets.
- **Enqueue (IDLE).** An eligible resolve is written if the FIFO is not full, or if it is full and a pop happens in the same cycle. Otherwise `dropped` pulses in the following cycle. Eligible resolves are never back-pressured.
- **Drain (IDLE).** When the FIFO is non-empty and `drain_en` is high:
  - the head is popped;
  - `btb_update`, `btb_update_addr` and `btb_update_target` are driven combinationally from the head;
  - one entry leaves per cycle.
- **Bypass.** An empty-FIFO bypass is not allowed; every update passes through the FIFO.
- **Entering SWEEP.** `flush_req` in IDLE moves to SWEEP on the next edge. On that edge:
  - the FIFO is cleared; its pending updates are discarded;
  - the set counter is set to 0.
  - An eligible resolve in the same cycle as `flush_req` is discarded, without `dropped`.
- **SWEEP.**
  - Each cycle: `btb_inval=1`, `btb_inval_set`=counter, then the counter increments.
  - The sweep ignores `drain_en`; invalidation has priority over fetch.
  - After set 2^SET_WIDTH-1 is invalidated, return to IDLE.
  - Resolves during SWEEP are discarded silently, with `dropped` low.
  - `flush_req` during SWEEP restarts the counter at 0.
- **Output exclusivity.** `btb_update` and `btb_inval` are never high in the same cycle.

## Timing
- **Reset values.**
  - Outputs: `btb_update=0`, `btb_inval=0`, `btb_inval_set=0`, `flush_busy=0`, `dropped=0`.
  - Internal: state IDLE, FIFO empty.
  - Reset mid-sweep abandons the sweep. Reset has priority over every other input.
- **Update latency.** A resolve sampled at edge k gives `btb_update` high in cycle k+1 at the earliest (with `drain_en` high).
- **Sweep length.** From `flush_req` sampled at edge k:
  - `flush_busy` and `btb_inval` are high for exactly 2^SET_WIDTH cycles, starting at cycle k+1;
  - IDLE resumes at cycle k+1+2^SET_WIDTH.
- **FIFO indexing.** Pointers are log2(DEPTH)+1 bits and wrap modulo 2·DEPTH. Full = MSBs differ and low bits equal.
- **Full-FIFO simultaneity.** With the FIFO full, enqueue and pop in the same cycle keep the occupancy at DEPTH.

## Configuration
- `BTB_UPDATE_FILTER_EN` defined: an eligible resolve with `resolve_pred_hit && resolve_pred_target == resolve_target` is not enqueued. The BTB already holds the correct entry, and `dropped` is not asserted for such a resolve.
- Undefined: every eligible resolve is enqueued. The prediction inputs are unused.

## Test plan
- **Drain latency.** Reset, `drain_en=1`; resolve pc 0x100, taken, target 0x200 → `btb_update` one cycle later with addr 0x100, target 0x200; FIFO empty afterwards.
- **Overflow.** `drain_en=0`; 5 eligible resolves (DEPTH=4) → `dropped` pulses once. Raising `drain_en` → 4 updates in 4 consecutive cycles, in order.
- **Full, simultaneous events.** FIFO full; `drain_en=1` and an eligible resolve in the same cycle → no `dropped`; occupancy stays 4.
- **Flush.** 2 entries queued, then `flush_req`:
  - 256 consecutive `btb_inval` cycles, sets 0..255;
  - `btb_update` never high during or after the sweep for the discarded entries;
  - `flush_busy` falls after set 255.
- **Restart, reset and filter.**
  - `flush_req` again at set 100 → the sweep restarts at 0 and lasts 256 more cycles.
  - `rst` at set 50 → IDLE, all outputs 0 on the next cycle.
  - With `BTB_UPDATE_FILTER_EN`: resolve pred_hit=1, pred_target=target=0x300 → no `btb_update`.
  - Same resolve with pred_target=0x304 → `btb_update` with target 0x300.
